// File: rtl/layer_scheduler_pkg.sv
// Shared definitions for the layer scheduler: state encoding and the index-width helper
// reused by the neuron and activation-buffer blocks.
package layer_scheduler_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_WRITE = 3'd3,
        ST_SWAP  = 3'd4,
        ST_DONE  = 3'd5,
        ST_ERROR = 3'd6
    } state_t;

    // Address width for a count of x entries, never narrower than one bit.
    function automatic int idx_width(input int x);
        return (x <= 2) ? 1 : $clog2(x);
    endfunction

endpackage

// File: rtl/layer_scheduler_index_counter.sv
// Saturating up-counter with modulus MOD: synchronous init to 0, increment that stops at MOD-1,
// and a last flag at MOD-1.
module index_counter
    import layer_scheduler_pkg::*;
#(
    parameter int MOD = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      init_i,
    input  logic                      inc_i,
    output logic [idx_width(MOD)-1:0] count_o,
    output logic                      last_o
);
    localparam int W = idx_width(MOD);

    logic [W-1:0] count_q, count_d;

    // Compared against MOD-1 rather than all-ones so non-power-of-two sizes stop exactly.
    assign last_o = (count_q == W'(MOD - 1));

    always_comb begin
        count_d = count_q;
        if (init_i) begin
            count_d = '0;
        end else if (inc_i && !last_o) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/layer_scheduler.sv
// Walks every neuron of every layer through one shared neuron datapath, swapping the ping-pong
// activation buffers between layers, with a watchdog that traps a neuron that never answers.
module layer_scheduler
    import layer_scheduler_pkg::*;
#(
    parameter int N_IN     = 10,
    parameter int N_OUT    = 8,
    parameter int N_LAYERS = 2,
    parameter int TIMEOUT  = 64
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           start_i,
    input  logic                           neuron_ready_i,
    output logic                           neuron_start_o,
    output logic [idx_width(N_OUT)-1:0]    neuron_idx_o,
    output logic [idx_width(N_LAYERS)-1:0] layer_idx_o,
    output logic                           wr_en_o,
    output logic                           swap_o,
    output logic                           busy_o,
    output logic                           done_o,
    output logic                           error_o
);
    localparam int TW = idx_width(TIMEOUT);

    if (N_IN < 1 || N_OUT < 1 || N_LAYERS < 1 || TIMEOUT < 2) begin : g_param_check
        $error("layer_scheduler: parameter out of range");
    end

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          error_q, error_d;
    logic          n_init, n_inc, n_last;
    logic          l_init, l_inc, l_last;
    logic          timer_last;

    index_counter #(.MOD(N_OUT)) u_neuron_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .init_i  (n_init),
        .inc_i   (n_inc),
        .count_o (neuron_idx_o),
        .last_o  (n_last)
    );

    index_counter #(.MOD(N_LAYERS)) u_layer_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .init_i  (l_init),
        .inc_i   (l_inc),
        .count_o (layer_idx_o),
        .last_o  (l_last)
    );

    assign timer_last = (timer_q == TW'(TIMEOUT - 1));

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        error_d = error_q;
        n_init  = 1'b0;
        n_inc   = 1'b0;
        l_init  = 1'b0;
        l_inc   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                n_init = 1'b1;
                l_init = 1'b1;
                if (start_i) begin
                    state_d = ST_ISSUE;
                    error_d = 1'b0;
                end
            end
            ST_ISSUE: begin
                timer_d = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // A ready arriving on the final watchdog cycle still counts as an answer.
                if (neuron_ready_i) begin
                    state_d = ST_WRITE;
                end else if (timer_last) begin
                    state_d = ST_ERROR;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            ST_WRITE: begin
                if (n_last) begin
                    state_d = ST_SWAP;
                end else begin
                    n_inc   = 1'b1;
                    state_d = ST_ISSUE;
                end
            end
            ST_SWAP: begin
                n_init = 1'b1;
                if (l_last) begin
                    state_d = ST_DONE;
                end else begin
                    l_inc   = 1'b1;
                    state_d = ST_ISSUE;
                end
            end
            ST_DONE: begin
                n_init  = 1'b1;
                l_init  = 1'b1;
                state_d = ST_IDLE;
            end
            ST_ERROR: begin
                error_d = 1'b1;
                n_init  = 1'b1;
                l_init  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            error_q <= error_d;
        end
    end

    assign neuron_start_o = (state_q == ST_ISSUE);
    assign wr_en_o        = (state_q == ST_WRITE);
    assign swap_o         = (state_q == ST_SWAP);
    assign done_o         = (state_q == ST_DONE);
    assign busy_o         = (state_q != ST_IDLE);
    assign error_o        = error_q;

endmodule

// File: tb/tb_layer_scheduler.sv
// Self-checking bench: a per-cycle expected timeline is built from per-neuron ready delays
// and compared against two scheduler instances of different sizes.
module tb_layer_scheduler;
    import layer_scheduler_pkg::*;

    localparam int A_NO = 8, A_NL = 2, A_TO = 4;
    localparam int B_NO = 3, B_NL = 1, B_TO = 64;
    localparam int MAXC = 256;

    logic clk = 1'b0;
    logic rst;
    logic a_start, a_ready, b_start, b_ready;
    logic a_ns, a_wr, a_sw, a_busy, a_done, a_err;
    logic b_ns, b_wr, b_sw, b_busy, b_done, b_err;
    logic [idx_width(A_NO)-1:0] a_nidx;
    logic [idx_width(A_NL)-1:0] a_lidx;
    logic [idx_width(B_NO)-1:0] b_nidx;
    logic [idx_width(B_NL)-1:0] b_lidx;
    logic [13:0] obs_a, obs_b;

    always #5 clk = ~clk;

    layer_scheduler #(.N_IN(10), .N_OUT(A_NO), .N_LAYERS(A_NL), .TIMEOUT(A_TO)) dut_a (
        .clk_i(clk), .rst_i(rst), .start_i(a_start), .neuron_ready_i(a_ready),
        .neuron_start_o(a_ns), .neuron_idx_o(a_nidx), .layer_idx_o(a_lidx),
        .wr_en_o(a_wr), .swap_o(a_sw), .busy_o(a_busy), .done_o(a_done), .error_o(a_err)
    );

    layer_scheduler #(.N_IN(5), .N_OUT(B_NO), .N_LAYERS(B_NL), .TIMEOUT(B_TO)) dut_b (
        .clk_i(clk), .rst_i(rst), .start_i(b_start), .neuron_ready_i(b_ready),
        .neuron_start_o(b_ns), .neuron_idx_o(b_nidx), .layer_idx_o(b_lidx),
        .wr_en_o(b_wr), .swap_o(b_sw), .busy_o(b_busy), .done_o(b_done), .error_o(b_err)
    );

    assign obs_a = {a_ns, a_wr, a_sw, a_done, a_busy, a_err, 4'(a_nidx), 4'(a_lidx)};
    assign obs_b = {b_ns, b_wr, b_sw, b_done, b_busy, b_err, 4'(b_nidx), 4'(b_lidx)};

    int          vectors = 0;
    int          miscompares = 0;
    logic [13:0] exp_v [0:MAXC-1];
    bit          rdy   [0:MAXC-1];
    int          dly   [0:63];
    int          len;
    bit          noise;
    bit          err_now;

    // Bit layout: start, wr_en, swap, done, busy, error, neuron_idx[3:0], layer_idx[3:0]
    function automatic logic [13:0] pack(input bit ns, input bit wr, input bit sw, input bit dn,
                                         input bit bz, input bit er, input int ni, input int li);
        return {ns, wr, sw, dn, bz, er, ni[3:0], li[3:0]};
    endfunction

    task automatic check(input bit sel, input logic [13:0] e, input string tag, input int c);
        logic [13:0] o;
        o = sel ? obs_b : obs_a;
        vectors++;
        assert (o === e) else begin
            miscompares++;
            $error("FAIL %s cycle %0d: observed %b expected %b", tag, c, o, e);
        end
    endtask

    // Expected outputs per cycle; cycle 0 is the IDLE cycle where start is sampled.
    task automatic build(input int no, input int nl, input int to);
        int t;
        int d;
        for (int i = 0; i < MAXC; i++) begin
            exp_v[i] = '0;
            rdy[i]   = 1'b0;
        end
        exp_v[0] = pack(0, 0, 0, 0, 0, err_now, 0, 0);
        t = 1;
        for (int l = 0; l < nl; l++) begin
            for (int n = 0; n < no; n++) begin
                d = dly[l * no + n];
                exp_v[t] = pack(1, 0, 0, 0, 1, 0, n, l);
                if (d < to) begin
                    for (int w = 0; w <= d; w++) exp_v[t + 1 + w] = pack(0, 0, 0, 0, 1, 0, n, l);
                    rdy[t + 1 + d]   = 1'b1;
                    exp_v[t + 2 + d] = pack(0, 1, 0, 0, 1, 0, n, l);
                    t = t + d + 3;
                end else begin
                    for (int w = 0; w < to; w++) exp_v[t + 1 + w] = pack(0, 0, 0, 0, 1, 0, n, l);
                    exp_v[t + 1 + to] = pack(0, 0, 0, 0, 1, 0, n, l);
                    exp_v[t + 2 + to] = pack(0, 0, 0, 0, 0, 1, 0, 0);
                    len = t + 3 + to;
                    return;
                end
            end
            exp_v[t] = pack(0, 0, 1, 0, 1, 0, no - 1, l);
            t++;
        end
        exp_v[t]     = pack(0, 0, 0, 1, 1, 0, 0, nl - 1);
        exp_v[t + 1] = pack(0, 0, 0, 0, 0, 0, 0, 0);
        len = t + 2;
    endtask

    // Entered and left at 1 time unit after a rising edge.
    task automatic run(input bit sel, input int stop_at, input string tag);
        bit st, rd;
        for (int c = 0; c < stop_at; c++) begin
            st = (c == 0) || (noise && c < len - 1 && $urandom_range(0, 3) == 0);
            rd = rdy[c] || (noise && (exp_v[c][13] || exp_v[c][12] || exp_v[c][11] || exp_v[c][10]));
            if (sel) begin b_start = st; b_ready = rd; end
            else     begin a_start = st; a_ready = rd; end
            @(negedge clk);
            check(sel, exp_v[c], tag, c);
            @(posedge clk);
            #1;
        end
        a_start = 0; a_ready = 0; b_start = 0; b_ready = 0;
        if (stop_at == len) err_now = exp_v[len - 1][8];
    endtask

    task automatic idle_cycles(input bit sel, input int n, input string tag);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            check(sel, pack(0, 0, 0, 0, 0, err_now, 0, 0), tag, c);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic fill(input int n, input int lo, input int hi);
        for (int i = 0; i < 64; i++) dly[i] = (i < n) ? int'($urandom_range(hi, lo)) : 0;
    endtask

    initial begin
        a_start = 0; a_ready = 0; b_start = 0; b_ready = 0;
        noise = 0; err_now = 0;
        rst = 1'b1;
        #1;
        check(0, '0, "reset_a", 0);
        check(1, '0, "reset_b", 0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check(0, '0, "idle_a", c);
            check(1, '0, "idle_b", c);
            @(posedge clk);
            #1;
        end

        // Nominal d=2: done at cycle 83, swaps at 41 and 82.
        fill(A_NO * A_NL, 2, 2);
        build(A_NO, A_NL, A_TO);
        run(0, len, "nominal_d2");

        // Ready on the final watchdog cycle.
        fill(A_NO * A_NL, A_TO - 1, A_TO - 1);
        build(A_NO, A_NL, A_TO);
        run(0, len, "ready_last_wd");

        noise = 1;
        for (int r = 0; r < 3; r++) begin
            fill(A_NO * A_NL, 0, A_TO - 1);
            build(A_NO, A_NL, A_TO);
            run(0, len, "random_a");
        end
        noise = 0;

        // Timeout on a neuron mid-layer, sticky error, then cleared by the next start.
        fill(A_NO * A_NL, 0, 3);
        dly[5] = A_TO;
        build(A_NO, A_NL, A_TO);
        run(0, len, "timeout");
        idle_cycles(0, 5, "error_sticky");
        fill(A_NO * A_NL, 1, 3);
        build(A_NO, A_NL, A_TO);
        run(0, len, "after_error");

        // Zero-delay ready on the 3-neuron, 1-layer instance: wr at 3,6,9, swap 10, done 11.
        fill(B_NO * B_NL, 0, 0);
        build(B_NO, B_NL, B_TO);
        run(1, len, "zero_delay_b");
        noise = 1;
        for (int r = 0; r < 2; r++) begin
            fill(B_NO * B_NL, 0, 6);
            build(B_NO, B_NL, B_TO);
            run(1, len, "random_b");
        end
        noise = 0;

        // Reset during WAIT of layer 1, then a clean restart.
        fill(A_NO * A_NL, 2, 2);
        build(A_NO, A_NL, A_TO);
        run(0, 50, "pre_reset");
        rst = 1'b1;
        #1;
        check(0, '0, "rst_mid_run", 50);
        err_now = 0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        build(A_NO, A_NL, A_TO);
        run(0, len, "restart");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
